// File: rtl/alu_flag_unit_pkg.sv
// Shared encodings for the ALU status-flag unit: op codes, branch conditions,
// flag bit positions and the 4-bit flag vector type.
package alu_flag_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_CMP  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_LAST = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_1111 = 4'b1111;

    typedef enum logic [2:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_CS = 3'b011,
        COND_CC = 3'b100,
        COND_MI = 3'b101,
        COND_GE = 3'b110,
        COND_LT = 3'b111
    } cond_e;

    localparam int FZ = 0;
    localparam int FC = 1;
    localparam int FN = 2;
    localparam int FV = 3;

    typedef logic [3:0] flags_t;

    // Logic/shift ops only report Z; the rest of the flags are cleared.
    function automatic logic is_logic_op(input logic [3:0] op);
        return ((op >= OP_AND) && (op <= OP_LAST)) || (op == OP_1111);
    endfunction

endpackage

// File: rtl/alu_flag_unit_if.sv
// ALU-to-flag-unit bundle: update operands, flag-stack controls and status outputs.
// The slave side is the flag unit; the master side is the ALU/control driver.
interface alu_flag_unit_if #(parameter int N = 8);
    logic         upd_valid;
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] result;
    logic         c_out;
    logic         flag_load;
    logic [3:0]   flag_din;
    logic         push;
    logic         pop;
    logic         err_clr;
    logic [2:0]   cond;
    logic [3:0]   flags;
    logic         cond_true;
    logic         stk_full;
    logic         stk_empty;
    logic         stk_err;

    modport master (
        output upd_valid, op, a, b, result, c_out, flag_load, flag_din,
               push, pop, err_clr, cond,
        input  flags, cond_true, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  upd_valid, op, a, b, result, c_out, flag_load, flag_din,
               push, pop, err_clr, cond,
        output flags, cond_true, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/alu_flag_unit_flag_stack.sv
// LIFO of flag vectors with push, pop and exchange (push+pop); one-cycle update.
// No backpressure: illegal push/pop leave the stack untouched and pulse err_o.
module flag_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         err_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mem_q [2**AW];
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == DEPTH_C);
    assign top_idx = empty_o ? '0 : AW'(cnt_q - CW'(1));
    assign top_o   = mem_q[top_idx];

    always_comb begin
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = top_idx;
        err_o  = 1'b0;
        if (push_i && pop_i) begin
            // Exchange overwrites the top in place; an empty stack has no top to swap.
            if (empty_o) err_o = 1'b1;
            else         wr_en = 1'b1;
        end else if (push_i) begin
            if (full_o) begin
                err_o = 1'b1;
            end else begin
                wr_en  = 1'b1;
                wr_idx = AW'(cnt_q);
                cnt_d  = cnt_q + CW'(1);
            end
        end else if (pop_i) begin
            if (empty_o) err_o = 1'b1;
            else         cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= din_i;
    end

endmodule

// File: rtl/alu_flag_unit.sv
// Registered Z/C/N/V flags with save/restore stack and branch-condition evaluator.
// Flags update 1 cycle after a qualified op; cond_true is combinational; no backpressure.
module alu_flag_unit
    import alu_flag_pkg::*;
#(
    parameter int N          = 8,
    parameter int STK_DEPTH  = 4,
    parameter int SIGNED_CMP = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_flag_unit_if.slave bus
);
    flags_t flags_q, flags_d;
    flags_t upd_flags;
    logic   upd_hit;
    flags_t stk_top;
    logic   stk_empty, stk_full, stk_err_pulse;
    logic   stk_err_q, stk_err_d;

    flag_stack #(.DEPTH(STK_DEPTH), .W(4)) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.push),
        .pop_i   (bus.pop),
        .din_i   (flags_q),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .err_o   (stk_err_pulse)
    );

    always_comb begin
        upd_hit   = 1'b1;
        upd_flags = flags_q;
        case (bus.op)
            OP_ADD: begin
                upd_flags[FC] = bus.c_out;
                upd_flags[FZ] = (bus.result == '0);
                upd_flags[FN] = bus.result[N-1];
                upd_flags[FV] = (bus.a[N-1] == bus.b[N-1]) && (bus.result[N-1] != bus.a[N-1]);
            end
            OP_CMP: begin
                upd_flags[FZ] = (bus.b == bus.a);
                upd_flags[FN] = (SIGNED_CMP != 0) ? ($signed(bus.b) > $signed(bus.a))
                                                  : (bus.b > bus.a);
                upd_flags[FC] = (bus.b < bus.a);
                upd_flags[FV] = 1'b0;
            end
            OP_SUB: begin
                upd_flags[FC] = bus.c_out;
                upd_flags[FZ] = (bus.result == '0);
                upd_flags[FN] = bus.result[N-1];
                upd_flags[FV] = (bus.a[N-1] != bus.b[N-1]) && (bus.result[N-1] != bus.a[N-1]);
            end
            default: begin
                if (is_logic_op(bus.op)) upd_flags = {3'b000, (bus.result == '0)};
                else                     upd_hit   = 1'b0;
            end
        endcase
    end

    // A pop owns the flag register this cycle even when it fails on an empty stack.
    always_comb begin
        flags_d = flags_q;
        if (bus.pop) begin
            if (!stk_empty) flags_d = stk_top;
        end else if (bus.flag_load) begin
            flags_d = bus.flag_din;
        end else if (bus.upd_valid && upd_hit) begin
            flags_d = upd_flags;
        end
    end

    assign stk_err_d = stk_err_pulse | (stk_err_q & ~bus.err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= '0;
            stk_err_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            stk_err_q <= stk_err_d;
        end
    end

    always_comb begin
        bus.cond_true = 1'b1;
        case (cond_e'(bus.cond))
            COND_AL: bus.cond_true = 1'b1;
            COND_EQ: bus.cond_true = flags_q[FZ];
            COND_NE: bus.cond_true = !flags_q[FZ];
            COND_CS: bus.cond_true = flags_q[FC];
            COND_CC: bus.cond_true = !flags_q[FC];
            COND_MI: bus.cond_true = flags_q[FN];
            COND_GE: bus.cond_true = (flags_q[FN] == flags_q[FV]);
            COND_LT: bus.cond_true = (flags_q[FN] != flags_q[FV]);
            default: bus.cond_true = 1'b1;
        endcase
    end

    assign bus.flags     = flags_q;
    assign bus.stk_full  = stk_full;
    assign bus.stk_empty = stk_empty;
    assign bus.stk_err   = stk_err_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: flag updates, condition decode, stack and async reset.
module tb_alu_flag_unit;
    import alu_flag_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_flag_unit_if #(.N(8)) ifm ();
    alu_flag_unit_if #(.N(8)) ifs ();

    // Second instance compares signed; it sees exactly the same inputs.
    assign ifs.upd_valid = ifm.upd_valid;
    assign ifs.op        = ifm.op;
    assign ifs.a         = ifm.a;
    assign ifs.b         = ifm.b;
    assign ifs.result    = ifm.result;
    assign ifs.c_out     = ifm.c_out;
    assign ifs.flag_load = ifm.flag_load;
    assign ifs.flag_din  = ifm.flag_din;
    assign ifs.push      = ifm.push;
    assign ifs.pop       = ifm.pop;
    assign ifs.err_clr   = ifm.err_clr;
    assign ifs.cond      = ifm.cond;

    alu_flag_unit #(.N(8), .STK_DEPTH(4), .SIGNED_CMP(0)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (ifm.slave)
    );

    alu_flag_unit #(.N(8), .STK_DEPTH(4), .SIGNED_CMP(1)) u_dut_s (
        .clk (clk), .rst_n (rst_n), .bus (ifs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_f(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifm.upd_valid = 1'b0;
        ifm.op        = 4'h0;
        ifm.a         = 8'h00;
        ifm.b         = 8'h00;
        ifm.result    = 8'h00;
        ifm.c_out     = 1'b0;
        ifm.flag_load = 1'b0;
        ifm.flag_din  = 4'h0;
        ifm.push      = 1'b0;
        ifm.pop       = 1'b0;
        ifm.err_clr   = 1'b0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic c);
        ifm.upd_valid = 1'b1;
        ifm.op        = op;
        ifm.a         = a;
        ifm.b         = b;
        ifm.result    = r;
        ifm.c_out     = c;
    endtask

    task automatic stk(input logic push, input logic pop, input logic load, input logic [3:0] din);
        idle();
        ifm.push      = push;
        ifm.pop       = pop;
        ifm.flag_load = load;
        ifm.flag_din  = din;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        idle();
        ifm.cond = COND_AL;
        #2;
        chk_f("rst_flags", ifm.flags, 4'b0000);
        chk_b("rst_empty", ifm.stk_empty, 1'b1);
        chk_b("rst_full", ifm.stk_full, 1'b0);
        chk_b("rst_err", ifm.stk_err, 1'b0);
        chk_b("rst_cond_al", ifm.cond_true, 1'b1);
        ifm.cond = COND_EQ;
        #1;
        chk_b("rst_cond_eq", ifm.cond_true, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // ADD 7F+01=80: signed overflow into negative
        alu(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0);
        tick();
        idle();
        chk_f("add_ovf", ifm.flags, 4'b1100);
        ifm.cond = COND_GE;
        #1;
        chk_b("add_ge", ifm.cond_true, 1'b1);
        ifm.cond = COND_LT;
        #1;
        chk_b("add_lt", ifm.cond_true, 1'b0);

        // SUB 80-01=7F: signed overflow into positive
        alu(OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0);
        tick();
        idle();
        chk_f("sub_ovf", ifm.flags, 4'b1000);
        chk_b("sub_lt", ifm.cond_true, 1'b1);

        // Unqualified op: flags hold
        alu(OP_ADD, 8'h00, 8'h00, 8'h00, 1'b1);
        ifm.upd_valid = 1'b0;
        tick();
        chk_f("no_valid_hold", ifm.flags, 4'b1000);

        alu(OP_CMP, 8'h05, 8'h05, 8'h00, 1'b0);
        tick();
        idle();
        chk_f("cmp_eq", ifm.flags, 4'b0001);
        ifm.cond = COND_EQ;
        #1;
        chk_b("cmp_eq_cond", ifm.cond_true, 1'b1);

        alu(OP_CMP, 8'h03, 8'hF0, 8'h00, 1'b0);
        tick();
        idle();
        chk_f("cmp_unsigned", ifm.flags, 4'b0100);
        chk_f("cmp_signed", ifs.flags, 4'b0000);
        ifm.cond = COND_MI;
        #1;
        chk_b("cmp_mi", ifm.cond_true, 1'b1);

        alu(OP_AND, 8'h12, 8'h34, 8'h00, 1'b1);
        tick();
        idle();
        chk_f("logic_zero", ifm.flags, 4'b0001);

        alu(4'b1010, 8'h12, 8'h34, 8'h55, 1'b1);
        tick();
        idle();
        chk_f("undef_op_hold", ifm.flags, 4'b0001);

        // Fill stack with 1..4, overflow, then drain and underflow
        stk(1'b0, 1'b0, 1'b1, 4'h1);
        stk(1'b1, 1'b0, 1'b1, 4'h2);
        stk(1'b1, 1'b0, 1'b1, 4'h3);
        stk(1'b1, 1'b0, 1'b1, 4'h4);
        stk(1'b1, 1'b0, 1'b0, 4'h0);
        chk_b("fill_full", ifm.stk_full, 1'b1);
        chk_b("fill_no_err", ifm.stk_err, 1'b0);
        stk(1'b1, 1'b0, 1'b1, 4'h5);
        chk_b("ovf_err", ifm.stk_err, 1'b1);
        chk_f("ovf_load_applies", ifm.flags, 4'h5);
        stk(1'b0, 1'b1, 1'b0, 4'h0);
        chk_f("pop1", ifm.flags, 4'h4);
        stk(1'b0, 1'b1, 1'b0, 4'h0);
        chk_f("pop2", ifm.flags, 4'h3);
        stk(1'b0, 1'b1, 1'b0, 4'h0);
        chk_f("pop3", ifm.flags, 4'h2);
        stk(1'b0, 1'b1, 1'b0, 4'h0);
        chk_f("pop4", ifm.flags, 4'h1);
        chk_b("drain_empty", ifm.stk_empty, 1'b1);
        stk(1'b0, 1'b1, 1'b1, 4'h7);
        chk_f("udf_hold", ifm.flags, 4'h1);
        chk_b("udf_err", ifm.stk_err, 1'b1);
        stk(1'b0, 1'b0, 1'b0, 4'h0);
        ifm.err_clr = 1'b1;
        tick();
        idle();
        chk_b("err_clr", ifm.stk_err, 1'b0);

        // Priority and exchange: build stack [9,2] with flags=5
        stk(1'b0, 1'b0, 1'b1, 4'h9);
        stk(1'b1, 1'b0, 1'b1, 4'h2);
        stk(1'b1, 1'b0, 1'b1, 4'h5);
        idle();
        alu(OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0);
        ifm.pop       = 1'b1;
        ifm.flag_load = 1'b1;
        ifm.flag_din  = 4'hF;
        tick();
        idle();
        chk_f("pop_priority", ifm.flags, 4'h2);
        stk(1'b1, 1'b1, 1'b0, 4'h0);
        chk_f("xchg_flags", ifm.flags, 4'h9);
        chk_b("xchg_not_empty", ifm.stk_empty, 1'b0);
        stk(1'b0, 1'b1, 1'b0, 4'h0);
        chk_f("xchg_top", ifm.flags, 4'h2);
        chk_b("xchg_empty", ifm.stk_empty, 1'b1);
        stk(1'b1, 1'b1, 1'b0, 4'h0);
        chk_b("xchg_empty_err", ifm.stk_err, 1'b1);
        chk_f("xchg_empty_hold", ifm.flags, 4'h2);
        chk_b("xchg_empty_cnt", ifm.stk_empty, 1'b1);
        idle();
        ifm.pop     = 1'b1;
        ifm.err_clr = 1'b1;
        tick();
        idle();
        chk_b("clr_vs_err", ifm.stk_err, 1'b1);
        ifm.err_clr = 1'b1;
        tick();
        idle();
        chk_b("clr_again", ifm.stk_err, 1'b0);

        // Async reset with count=3, flags=A, sticky error set
        stk(1'b0, 1'b1, 1'b0, 4'h0);
        stk(1'b1, 1'b0, 1'b1, 4'h1);
        stk(1'b1, 1'b0, 1'b0, 4'h0);
        stk(1'b1, 1'b0, 1'b1, 4'hA);
        idle();
        chk_f("pre_rst_flags", ifm.flags, 4'hA);
        chk_b("pre_rst_err", ifm.stk_err, 1'b1);
        chk_b("pre_rst_not_empty", ifm.stk_empty, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_f("arst_flags", ifm.flags, 4'h0);
        chk_b("arst_empty", ifm.stk_empty, 1'b1);
        chk_b("arst_err", ifm.stk_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
